// File: rtl/axi4_lite_cnt_th_master.sv
// axi4_lite_cnt_th_master
//   AXI4-Lite master that programs the four 32-bit threshold registers of the
//   counter/LED peripheral. An accepted start latches the thresholds and writes
//   them to base+0x0/0x4/0x8/0xC. It then reads each register back and compares
//   the result against the latched copy. The sequence always runs all eight
//   transactions. The first failing index (bad response or readback mismatch)
//   is reported.
//
// Ports
//   M00_AXI_ACLK / M00_AXI_ARESETN : clock, asynchronous active-low reset
//   i_start                        : 1-cycle request, honoured only in IDLE
//   i_th0..i_th3                   : threshold values, latched on accepted start
//   o_busy                         : sequence in progress (through DONE)
//   o_done                         : 1-cycle pulse at sequence end
//   o_err / o_err_idx              : sticky error flag and first failing index
//   M00_AXI_*                      : AXI4-Lite master interface (AW, W, B, AR, R)

module axi4_lite_cnt_th_master #(
    parameter int unsigned C_M00_AXI_ADDR_WIDTH = 4,
    parameter int unsigned C_M00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_BASE_ADDR          = 0
) (
    input  logic                                M00_AXI_ACLK,
    input  logic                                M00_AXI_ARESETN,
    input  logic                                i_start,
    input  logic [31:0]                         i_th0,
    input  logic [31:0]                         i_th1,
    input  logic [31:0]                         i_th2,
    input  logic [31:0]                         i_th3,
    output logic                                o_busy,
    output logic                                o_done,
    output logic                                o_err,
    output logic [1:0]                          o_err_idx,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     M00_AXI_AWADDR,
    output logic [2:0]                          M00_AXI_AWPROT,
    output logic                                M00_AXI_AWVALID,
    input  logic                                M00_AXI_AWREADY,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]     M00_AXI_WDATA,
    output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   M00_AXI_WSTRB,
    output logic                                M00_AXI_WVALID,
    input  logic                                M00_AXI_WREADY,
    input  logic [1:0]                          M00_AXI_BRESP,
    input  logic                                M00_AXI_BVALID,
    output logic                                M00_AXI_BREADY,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]     M00_AXI_ARADDR,
    output logic [2:0]                          M00_AXI_ARPROT,
    output logic                                M00_AXI_ARVALID,
    input  logic                                M00_AXI_ARREADY,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]     M00_AXI_RDATA,
    input  logic [1:0]                          M00_AXI_RRESP,
    input  logic                                M00_AXI_RVALID,
    output logic                                M00_AXI_RREADY
);

    localparam int unsigned AW = C_M00_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M00_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] BASE_ADDR = AW'(C_BASE_ADDR);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [1:0]      idx_reg;
    logic [DW-1:0]   th_reg [4];
    logic            aw_done_reg;
    logic            w_done_reg;
    logic            awvalid_reg;
    logic            wvalid_reg;
    logic            bready_reg;
    logic            arvalid_reg;
    logic            rready_reg;
    logic            busy_reg;
    logic            done_reg;
    logic            err_reg;
    logic [1:0]      err_idx_reg;

    logic            aw_hs;
    logic            w_hs;
    logic [AW-1:0]   reg_addr;

    assign aw_hs = awvalid_reg & M00_AXI_AWREADY;
    assign w_hs  = wvalid_reg & M00_AXI_WREADY;

    // idx only changes between transactions, so address and data derived from
    // it stay stable for as long as any VALID is high.
    assign reg_addr = BASE_ADDR + AW'({idx_reg, 2'b00});

    assign M00_AXI_AWADDR  = reg_addr;
    assign M00_AXI_ARADDR  = reg_addr;
    assign M00_AXI_AWPROT  = 3'b000;
    assign M00_AXI_ARPROT  = 3'b000;
    assign M00_AXI_WDATA   = th_reg[idx_reg];
    assign M00_AXI_WSTRB   = '1;
    assign M00_AXI_AWVALID = awvalid_reg;
    assign M00_AXI_WVALID  = wvalid_reg;
    assign M00_AXI_BREADY  = bready_reg;
    assign M00_AXI_ARVALID = arvalid_reg;
    assign M00_AXI_RREADY  = rready_reg;
    assign o_busy          = busy_reg;
    assign o_done          = done_reg;
    assign o_err           = err_reg;
    assign o_err_idx       = err_idx_reg;

    always_ff @(posedge M00_AXI_ACLK or negedge M00_AXI_ARESETN) begin
        if (!M00_AXI_ARESETN) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= 2'd0;
            for (int i = 0; i < 4; i++) th_reg[i] <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_idx_reg <= 2'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        th_reg[0]   <= i_th0;
                        th_reg[1]   <= i_th1;
                        th_reg[2]   <= i_th2;
                        th_reg[3]   <= i_th3;
                        idx_reg     <= 2'd0;
                        err_reg     <= 1'b0;
                        err_idx_reg <= 2'd0;
                        busy_reg    <= 1'b1;
                        awvalid_reg <= 1'b1;
                        wvalid_reg  <= 1'b1;
                        state_reg   <= ST_WR_ADDR_DATA;
                    end
                end

                ST_WR_ADDR_DATA: begin
                    // AW and W complete independently; remember which one is
                    // already done so neither channel issues a second beat.
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_reg <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        bready_reg  <= 1'b1;
                        state_reg   <= ST_WR_RESP;
                    end
                end

                ST_WR_RESP: begin
                    if (M00_AXI_BVALID) begin
                        bready_reg <= 1'b0;
                        if (M00_AXI_BRESP != 2'b00 && !err_reg) begin
                            err_reg     <= 1'b1;
                            err_idx_reg <= idx_reg;
                        end
                        if (idx_reg != 2'd3) begin
                            idx_reg     <= idx_reg + 2'd1;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= ST_WR_ADDR_DATA;
                        end else begin
                            idx_reg     <= 2'd0;
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_RD_ADDR;
                        end
                    end
                end

                ST_RD_ADDR: begin
                    if (M00_AXI_ARREADY) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= ST_RD_DATA;
                    end
                end

                ST_RD_DATA: begin
                    if (M00_AXI_RVALID) begin
                        rready_reg <= 1'b0;
                        if ((M00_AXI_RRESP != 2'b00 || M00_AXI_RDATA != th_reg[idx_reg])
                            && !err_reg) begin
                            err_reg     <= 1'b1;
                            err_idx_reg <= idx_reg;
                        end
                        if (idx_reg != 2'd3) begin
                            idx_reg     <= idx_reg + 2'd1;
                            arvalid_reg <= 1'b1;
                            state_reg   <= ST_RD_ADDR;
                        end else begin
                            idx_reg   <= 2'd0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_cnt_th_master.sv
// Directed bench for axi4_lite_cnt_th_master with a small AXI4-Lite slave model
// (register file, optional AWREADY delay, per-index BRESP and corrupted RDATA).

module tb_axi4_lite_cnt_th_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        i_start = 1'b0;
    logic [31:0] th0 = '0, th1 = '0, th2 = '0, th3 = '0;
    logic        busy, done, err;
    logic [1:0]  err_idx;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        s_awready, s_wready, s_arready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic        s_bvalid = 1'b0, s_rvalid = 1'b0;
    logic [31:0] s_rdata = '0;

    axi4_lite_cnt_th_master dut (
        .M00_AXI_ACLK    (clk),
        .M00_AXI_ARESETN (rst_n),
        .i_start         (i_start),
        .i_th0           (th0),
        .i_th1           (th1),
        .i_th2           (th2),
        .i_th3           (th3),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err),
        .o_err_idx       (err_idx),
        .M00_AXI_AWADDR  (awaddr),
        .M00_AXI_AWPROT  (awprot),
        .M00_AXI_AWVALID (awvalid),
        .M00_AXI_AWREADY (s_awready),
        .M00_AXI_WDATA   (wdata),
        .M00_AXI_WSTRB   (wstrb),
        .M00_AXI_WVALID  (wvalid),
        .M00_AXI_WREADY  (s_wready),
        .M00_AXI_BRESP   (s_bresp),
        .M00_AXI_BVALID  (s_bvalid),
        .M00_AXI_BREADY  (bready),
        .M00_AXI_ARADDR  (araddr),
        .M00_AXI_ARPROT  (arprot),
        .M00_AXI_ARVALID (arvalid),
        .M00_AXI_ARREADY (s_arready),
        .M00_AXI_RDATA   (s_rdata),
        .M00_AXI_RRESP   (s_rresp),
        .M00_AXI_RVALID  (s_rvalid),
        .M00_AXI_RREADY  (rready)
    );

    // ---------------- slave model ----------------
    int          aw_delay = 0;
    logic [1:0]  bresp_tbl [4] = '{2'b00, 2'b00, 2'b00, 2'b00};
    logic [3:0]  rd_bad = 4'b0000;
    logic        slv_clr = 1'b0;

    int          aw_wait = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          aw_hi = 0, w_hi = 0;
    logic        aw_have = 1'b0, w_have = 1'b0;
    logic [3:0]  aw_addr_q = '0;
    logic [31:0] w_data_q = '0;
    logic [3:0]  aw_log [16];
    logic [31:0] w_log  [16];
    logic [3:0]  ar_log [16];
    logic [31:0] mem    [4];

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_now, w_now;
    assign s_awready = (aw_wait >= aw_delay);
    assign s_wready  = 1'b1;
    assign s_arready = 1'b1;
    assign aw_hs  = awvalid & s_awready;
    assign w_hs   = wvalid & s_wready;
    assign b_hs   = s_bvalid & bready;
    assign ar_hs  = arvalid & s_arready;
    assign r_hs   = s_rvalid & rready;
    assign aw_now = aw_have | aw_hs;
    assign w_now  = w_have | w_hs;

    always @(posedge clk) begin
        if (!rst_n || slv_clr) begin
            aw_wait <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_hi <= 0; w_hi <= 0; aw_have <= 1'b0; w_have <= 1'b0;
            s_bvalid <= 1'b0; s_rvalid <= 1'b0;
        end else begin
            if (awvalid) aw_hi <= aw_hi + 1;
            if (wvalid)  w_hi  <= w_hi + 1;
            if (awvalid && !s_awready) aw_wait <= aw_wait + 1;
            if (aw_hs) begin
                aw_wait <= 0;
                aw_log[aw_cnt[3:0]] <= awaddr;
                aw_addr_q <= awaddr;
                aw_have <= 1'b1;
                aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                w_log[w_cnt[3:0]] <= wdata;
                w_data_q <= wdata;
                w_have <= 1'b1;
                w_cnt <= w_cnt + 1;
            end
            if (aw_now && w_now && !s_bvalid) begin
                mem[aw_hs ? awaddr[3:2] : aw_addr_q[3:2]] <= w_hs ? wdata : w_data_q;
                s_bvalid <= 1'b1;
                s_bresp  <= bresp_tbl[b_cnt[1:0]];
                aw_have  <= 1'b0;
                w_have   <= 1'b0;
            end
            if (b_hs) begin
                s_bvalid <= 1'b0;
                b_cnt <= b_cnt + 1;
            end
            if (ar_hs) begin
                ar_log[ar_cnt[3:0]] <= araddr;
                ar_cnt   <= ar_cnt + 1;
                s_rvalid <= 1'b1;
                s_rresp  <= 2'b00;
                s_rdata  <= rd_bad[ar_cnt[1:0]] ? 32'h0000_DEAD : mem[araddr[3:2]];
            end
            if (r_hs) begin
                s_rvalid <= 1'b0;
                r_cnt <= r_cnt + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_slave();
        @(negedge clk);
        slv_clr = 1'b1;
        @(negedge clk);
        slv_clr = 1'b0;
    endtask

    // Presents i_start for one cycle; returns at the negedge of cycle 1
    // (the cycle after the accepting edge).
    task automatic start_seq(input logic [31:0] a, b, c, d);
        @(negedge clk);
        th0 = a; th1 = b; th2 = c; th3 = d;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int cyc0, output int cyc);
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_seq(input string t, input int cyc, input int exp_cyc,
                             input logic [31:0] a, b, c, d,
                             input logic exp_err, input logic [1:0] exp_idx);
        logic [31:0] th [4];
        th[0] = a; th[1] = b; th[2] = c; th[3] = d;
        check({t, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({t, "_busy_at_done"}, 64'(busy), 64'd1);
        check({t, "_err"}, 64'(err), 64'(exp_err));
        if (exp_err) check({t, "_err_idx"}, 64'(err_idx), 64'(exp_idx));
        check({t, "_aw_cnt"}, 64'(aw_cnt), 64'd4);
        check({t, "_w_cnt"},  64'(w_cnt),  64'd4);
        check({t, "_ar_cnt"}, 64'(ar_cnt), 64'd4);
        check({t, "_r_cnt"},  64'(r_cnt),  64'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_awaddr%0d", t, i), 64'(aw_log[i]), 64'(i * 4));
            check($sformatf("%s_wdata%0d", t, i),  64'(w_log[i]),  64'(th[i]));
            check($sformatf("%s_araddr%0d", t, i), 64'(ar_log[i]), 64'(i * 4));
        end
        @(negedge clk);
        check({t, "_done_pulse_end"}, 64'(done), 64'd0);
        check({t, "_busy_end"}, 64'(busy), 64'd0);
        $display("%s: sequence done at cycle %0d err=%0b err_idx=%0d", t, cyc, err, err_idx);
    endtask

    initial begin
        int cyc;
        int guard;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({awvalid, wvalid, bready, arvalid, rready, busy, done, err, err_idx}), 64'd0);
        check("reset_const", 64'({awprot, arprot, wstrb}), 64'h00F);
        rst_n = 1'b1;
        clear_slave();

        // 1: zero-wait slave
        start_seq(32'h10, 32'h20, 32'h30, 32'h40);
        check("t1_busy_cycle1", 64'(busy), 64'd1);
        wait_done(1, cyc);
        check_seq("t1", cyc, 17, 32'h10, 32'h20, 32'h30, 32'h40, 1'b0, 2'd0);

        // 2: AWREADY held off, WREADY immediate
        clear_slave();
        aw_delay = 2;
        start_seq(32'hA1, 32'hB2, 32'hC3, 32'hD4);
        wait_done(1, cyc);
        check("t2_awvalid_cycles", 64'(aw_hi), 64'd12);
        check("t2_wvalid_cycles",  64'(w_hi),  64'd4);
        check_seq("t2", cyc, 25, 32'hA1, 32'hB2, 32'hC3, 32'hD4, 1'b0, 2'd0);
        aw_delay = 0;

        // 3: corrupted readback at index 2
        clear_slave();
        rd_bad = 4'b0100;
        start_seq(32'h1111, 32'h2222, 32'h3333, 32'h4444);
        wait_done(1, cyc);
        check_seq("t3", cyc, 17, 32'h1111, 32'h2222, 32'h3333, 32'h4444, 1'b1, 2'd2);

        // 4: SLVERR on write 1 and mismatch on read 3 -> first index is 1
        clear_slave();
        rd_bad = 4'b1000;
        bresp_tbl[1] = 2'b10;
        start_seq(32'h5, 32'h6, 32'h7, 32'h8);
        wait_done(1, cyc);
        check_seq("t4", cyc, 17, 32'h5, 32'h6, 32'h7, 32'h8, 1'b1, 2'd1);
        bresp_tbl[1] = 2'b00;

        // 5: restart while busy is ignored; new start after done clears o_err
        clear_slave();
        rd_bad = 4'b0001;
        start_seq(32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003);
        check("t5_err_cleared_on_start", 64'(err), 64'd0);
        repeat (3) @(negedge clk);
        th0 = 32'h9; th1 = 32'h9; th2 = 32'h9; th3 = 32'h9;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(5, cyc);
        check_seq("t5a", cyc, 17, 32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003,
                  1'b1, 2'd0);
        check("t5_no_restart", 64'(busy), 64'd0);
        clear_slave();
        rd_bad = 4'b0000;
        start_seq(32'h77, 32'h88, 32'h99, 32'hAA);
        check("t5b_err_cleared", 64'(err), 64'd0);
        wait_done(1, cyc);
        check_seq("t5b", cyc, 17, 32'h77, 32'h88, 32'h99, 32'hAA, 1'b0, 2'd0);

        // 6: asynchronous reset in WR_RESP
        clear_slave();
        start_seq(32'h1, 32'h2, 32'h3, 32'h4);
        guard = 0;
        while (bready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("t6_reached_wr_resp", 64'(bready), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_outputs_in_reset",
              64'({awvalid, wvalid, bready, arvalid, rready, busy, done}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_idle_after_reset", 64'({busy, awvalid, arvalid}), 64'd0);
        start_seq(32'hF0, 32'hF1, 32'hF2, 32'hF3);
        wait_done(1, cyc);
        check_seq("t6", cyc, 17, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
